// File: rtl/rom_arb_pkg.sv
// ---------------------------------------------------------------------------
// rom_arb_pkg
// Shared types and elaboration helpers for the ROM read-port arbiter.
//   MAX_NREQ   : widest requester count the tag struct can carry.
//   rom_tag_t  : one stage of the return-tag pipeline {valid, one-hot id}.
//   params_ok  : parameter legality check used at elaboration time.
// ---------------------------------------------------------------------------
package rom_arb_pkg;

    localparam int MAX_NREQ = 16;

    // The id field is sized for MAX_NREQ; only the low NREQ bits are ever set.
    typedef struct packed {
        logic                valid;
        logic [MAX_NREQ-1:0] id;
    } rom_tag_t;

    function automatic bit params_ok(input int nreq, input int rd_lat, input int starve_max);
        return (nreq >= 2) && (nreq <= MAX_NREQ) && (rd_lat >= 1) && (starve_max >= 1);
    endfunction

endpackage

// File: rtl/rom_rr_picker.sv
// ---------------------------------------------------------------------------
// rom_rr_picker
// Combinational cyclic first-one finder over requesters 1..N-1.
// The scan starts at ptr and wraps from N-1 back to 1; requester 0 is never
// considered here (it is handled by the fixed-priority path in the top).
// Ports:
//   req  in  [N-1:1]  request bits of the round-robin requesters
//   ptr  in  PW       scan start index, legal range 1..N-1
//   pick out N        one-hot result (bit 0 always 0), all-zero if no request
//   idx  out PW       index of the picked requester, 0 if none
// ---------------------------------------------------------------------------
module rom_rr_picker
    import rom_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:1]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] idx
);

    always_comb begin
        int   cand;
        logic found;
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N - 1; k++) begin
            cand = int'(ptr) + k;
            // Wrap past N-1 back to index 1 (index 0 is not part of the ring).
            if (cand >= N) begin
                cand = cand - (N - 1);
            end
            if (!found && req[cand]) begin
                found      = 1'b1;
                pick[cand] = 1'b1;
                idx        = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// ---------------------------------------------------------------------------
// rom_arbiter
// Shares one synchronous ROM read port between NREQ requesters. Requester 0
// (video fetch) has fixed priority, limited by a starvation guard; requesters
// 1..NREQ-1 are served round-robin. Each issued read carries a one-hot tag
// through an RD_LAT-deep pipeline so the returning word is steered back to
// its issuer.
// Parameters: AW address width, DW data width, NREQ requesters (>=2),
//             RD_LAT ROM latency (>=1), STARVE_MAX consecutive requester-0
//             grants allowed while others wait (>=1).
// Ports:
//   clock        in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   req          in   [NREQ]     per-requester level request
//   addr         in   [NREQ*AW]  requester i address at [i*AW +: AW]
//   gnt          out  [NREQ]     one-hot, read issued this cycle
//   rvalid       out  [NREQ]     one-hot, rdata belongs to that requester
//   rdata        out  [DW]       pass-through of rom_q
//   rom_ce       out             ROM clock enable
//   rom_address  out  [AW]       ROM address
//   rom_q        in   [DW]       ROM data
//
// Handshake: a requester raises req[i] with addr stable and holds both until
// it sees gnt[i]=1 in the same cycle; every gnt cycle is exactly one accepted
// read. Keeping req[i] high with a fresh address the next cycle streams reads
// back-to-back. There is no back-pressure on returns: rvalid[i] arrives
// exactly RD_LAT cycles after gnt[i] and must be captured in that cycle.
// ---------------------------------------------------------------------------
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int NREQ       = 3,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] addr,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               rom_ce,
    output logic [AW-1:0]      rom_address,
    input  logic [DW-1:0]      rom_q
);

    localparam int            PW         = $clog2(NREQ);
    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [PW-1:0] LAST_IDX   = PW'(NREQ - 1);

    if (!params_ok(NREQ, RD_LAT, STARVE_MAX)) begin : g_param_err
        $error("rom_arbiter: illegal NREQ/RD_LAT/STARVE_MAX combination");
    end

    // Arbiter state
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_nxt;
    logic [SW-1:0]   starve_cnt;
    logic [SW-1:0]   starve_nxt;

    // Decision signals
    logic            others;
    logic            grant0;
    logic            rr_gnt;
    logic [NREQ-1:0] rr_pick;
    logic [PW-1:0]   rr_idx;
    logic [NREQ-1:0] gnt_raw;

    // Return-tag pipeline
    rom_tag_t        tag_in;
    rom_tag_t        tag_q [RD_LAT];
    rom_tag_t        tag_out;

    assign others = |req[NREQ-1:1];

    rom_rr_picker #(
        .N  (NREQ),
        .PW (PW)
    ) u_picker (
        .req  (req[NREQ-1:1]),
        .ptr  (rr_ptr),
        .pick (rr_pick),
        .idx  (rr_idx)
    );

    // Requester 0 wins unless others are waiting and it has already had
    // STARVE_MAX grants in a row against them.
    always_comb begin
        gnt_raw = '0;
        grant0  = req[0] && (!others || (starve_cnt < STARVE_LIM));
        if (grant0) begin
            gnt_raw[0] = 1'b1;
        end else if (others) begin
            gnt_raw = rr_pick;
        end
    end

    // Outputs are held quiet for the whole time reset is asserted.
    assign gnt    = reset_n ? gnt_raw : '0;
    assign rom_ce = |gnt;
    assign rr_gnt = |gnt[NREQ-1:1];

    always_comb begin
        rom_address = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                rom_address = addr[i*AW +: AW];
            end
        end
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (!others) begin
            starve_nxt = '0;
        end else if (gnt[0]) begin
            if (starve_cnt < STARVE_LIM) begin
                starve_nxt = starve_cnt + 1'b1;
            end
        end else if (rr_gnt) begin
            starve_nxt = '0;
        end

        rr_nxt = rr_ptr;
        if (rr_gnt) begin
            rr_nxt = (rr_idx == LAST_IDX) ? PW'(1) : rr_idx + 1'b1;
        end
    end

    always_comb begin
        tag_in                = '0;
        tag_in.valid          = rom_ce;
        tag_in.id[NREQ-1:0]   = gnt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= PW'(1);
            starve_cnt <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            rr_ptr     <= rr_nxt;
            starve_cnt <= starve_nxt;
            tag_q[0]   <= tag_in;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign tag_out = tag_q[RD_LAT-1];
    assign rvalid  = (reset_n && tag_out.valid) ? tag_out.id[NREQ-1:0] : '0;
    assign rdata   = rom_q;

    // Upper id bits exist only because the tag type is sized for MAX_NREQ.
    if (NREQ < MAX_NREQ) begin : g_pad
        logic unused_id_pad;
        assign unused_id_pad = |tag_out.id[MAX_NREQ-1:NREQ];
    end

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;

    localparam int AW        = 16;
    localparam int DW        = 8;
    localparam int NREQ      = 3;
    localparam int SMAX      = 3;
    localparam int LAT       = 1;
    localparam int LAT3      = 3;
    localparam int MODE_HOLD = 0;
    localparam int MODE_ONE  = 1;
    localparam int MODE_RAND = 2;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT (RD_LAT=1) ----------------
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               rom_ce;
    logic [AW-1:0]      rom_address;
    logic [DW-1:0]      rom_q;

    rom_arbiter #(.AW(AW), .DW(DW), .NREQ(NREQ), .RD_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .addr(addr), .gnt(gnt),
        .rvalid(rvalid), .rdata(rdata), .rom_ce(rom_ce), .rom_address(rom_address),
        .rom_q(rom_q)
    );

    // ---------------- DUT (RD_LAT=3) ----------------
    logic [NREQ-1:0]    req3;
    logic [NREQ*AW-1:0] addr3;
    logic [NREQ-1:0]    gnt3;
    logic [NREQ-1:0]    rvalid3;
    logic [DW-1:0]      rdata3;
    logic               rom_ce3;
    logic [AW-1:0]      rom_address3;
    logic [DW-1:0]      rom_q3;

    rom_arbiter #(.AW(AW), .DW(DW), .NREQ(NREQ), .RD_LAT(LAT3), .STARVE_MAX(SMAX)) dut3 (
        .clock(clock), .reset_n(reset_n), .req(req3), .addr(addr3), .gnt(gnt3),
        .rvalid(rvalid3), .rdata(rdata3), .rom_ce(rom_ce3), .rom_address(rom_address3),
        .rom_q(rom_q3)
    );

    // ---------------- ROM models ----------------
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clock) begin
        if (rom_ce) rom_q <= rom_word(rom_address);
    end

    logic [DW-1:0] r3_s1, r3_s2;
    always @(posedge clock) begin
        if (rom_ce3) r3_s1 <= rom_word(rom_address3);
        r3_s2  <= r3_s1;
        rom_q3 <= r3_s2;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [NREQ+DW-1:0] exp_q[$];
    int                 exp_cyc[$];
    logic [NREQ+DW-1:0] exp3_q[$];
    int                 exp3_cyc[$];
    logic [NREQ+DW-1:0] e_mon;
    logic [NREQ+DW-1:0] e_mon3;

    always @(negedge clock) begin
        if (!reset_n) begin
            check("rvalid_in_reset", 32'(rvalid), 32'(0));
        end else if (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
            e_mon = exp_q.pop_front();
            void'(exp_cyc.pop_front());
            check("rvalid", 32'(rvalid), 32'(e_mon[DW +: NREQ]));
            check("rdata", 32'(rdata), 32'(e_mon[DW-1:0]));
        end else begin
            check("rvalid_idle", 32'(rvalid), 32'(0));
        end
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            check("rvalid3_in_reset", 32'(rvalid3), 32'(0));
        end else if (exp3_cyc.size() > 0 && exp3_cyc[0] == cyc) begin
            e_mon3 = exp3_q.pop_front();
            void'(exp3_cyc.pop_front());
            check("rvalid3", 32'(rvalid3), 32'(e_mon3[DW +: NREQ]));
            check("rdata3", 32'(rdata3), 32'(e_mon3[DW-1:0]));
        end else begin
            check("rvalid3_idle", 32'(rvalid3), 32'(0));
        end
    end

    // ---------------- reference arbitration model ----------------
    int m_cnt = 0;
    int m_ptr = 1;

    task automatic model_step(input logic [NREQ-1:0] r, output logic [NREQ-1:0] eg);
        bit others;
        bit found;
        others = |r[NREQ-1:1];
        found  = 1'b0;
        eg     = '0;
        if (r[0] && (!others || m_cnt < SMAX)) begin
            eg[0] = 1'b1;
        end else if (others) begin
            for (int k = 0; k < NREQ - 1; k++) begin
                int j;
                j = 1 + ((m_ptr - 1 + k) % (NREQ - 1));
                if (!found && r[j]) begin
                    eg[j] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        if (!others)     m_cnt = 0;
        else if (eg[0])  m_cnt = (m_cnt < SMAX) ? m_cnt + 1 : m_cnt;
        else             m_cnt = 0;
        for (int j = 1; j < NREQ; j++) begin
            if (eg[j]) m_ptr = (j == NREQ - 1) ? 1 : j + 1;
        end
    endtask

    // ---------------- drivers ----------------
    logic [NREQ-1:0] want;
    logic [AW-1:0]   a_r [NREQ];
    logic [NREQ-1:0] dut_gnt;

    task automatic drive();
        req = want;
        for (int i = 0; i < NREQ; i++) addr[i*AW +: AW] = a_r[i];
    endtask

    // One clock of the main DUT: drive, check at negedge, update requesters.
    task automatic run_cycle(input int mode);
        logic [NREQ-1:0] eg;
        logic [AW-1:0]   ea;
        eg = '0;
        ea = '0;
        drive();
        @(negedge clock);
        if (!reset_n) begin
            check("gnt_in_reset", 32'(gnt), 32'(0));
            check("rom_ce_in_reset", 32'(rom_ce), 32'(0));
            check("rom_address_in_reset", 32'(rom_address), 32'(0));
        end else begin
            model_step(req, eg);
            check("gnt", 32'(gnt), 32'(eg));
            check("rom_ce", 32'(rom_ce), 32'(|eg));
            for (int i = 0; i < NREQ; i++) begin
                if (eg[i]) ea = addr[i*AW +: AW];
            end
            check("rom_address", 32'(rom_address), 32'(ea));
            if (eg != '0) begin
                exp_q.push_back({eg, rom_word(ea)});
                exp_cyc.push_back(cyc + LAT);
            end
        end
        dut_gnt = gnt;
        @(posedge clock);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (eg[i]) begin
                if (mode == MODE_HOLD) begin
                    a_r[i] = a_r[i] + 1'b1;
                end else if (mode == MODE_ONE) begin
                    want[i] = 1'b0;
                end else begin
                    want[i] = ($urandom_range(0, 3) != 0);
                    a_r[i]  = AW'($urandom_range(0, 65535));
                end
            end else if (mode == MODE_RAND && !want[i]) begin
                want[i] = ($urandom_range(0, 3) != 0);
                a_r[i]  = AW'($urandom_range(0, 65535));
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        exp_q.delete();
        exp_cyc.delete();
        exp3_q.delete();
        exp3_cyc.delete();
        m_cnt = 0;
        m_ptr = 1;
        repeat (n) run_cycle(MODE_HOLD);
        reset_n = 1'b1;
    endtask

    // One clock of the RD_LAT=3 DUT with only requester 1 active.
    task automatic cycle3(input logic v, input logic [AW-1:0] a1);
        logic [NREQ-1:0] eg;
        eg    = v ? 3'b010 : 3'b000;
        req3  = eg;
        addr3 = '0;
        addr3[AW +: AW] = a1;
        @(negedge clock);
        check("gnt3", 32'(gnt3), 32'(eg));
        check("rom_address3", 32'(rom_address3), v ? 32'(a1) : 32'(0));
        if (v) begin
            exp3_q.push_back({eg, rom_word(a1)});
            exp3_cyc.push_back(cyc + LAT3);
        end
        @(posedge clock);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int starve_seq [12] = '{1, 1, 1, 2, 1, 1, 1, 4, 1, 1, 1, 2};

    initial begin
        want  = '1;
        for (int i = 0; i < NREQ; i++) a_r[i] = AW'(16'h1000 * (i + 1));
        dut_gnt = '0;
        req3    = '0;
        addr3   = '0;

        // Power-on reset with every request high: outputs must stay quiet.
        do_reset(3);
        check("rr_ptr_after_reset", 32'(dut.rr_ptr), 32'(1));
        check("starve_cnt_after_reset", 32'(dut.starve_cnt), 32'(0));
        want = '0;
        run_cycle(MODE_HOLD);

        // Single read from requester 1.
        want = 3'b010;
        a_r[1] = 16'h0010;
        run_cycle(MODE_ONE);
        check("single_gnt", 32'(dut_gnt), 32'(3'b010));
        run_cycle(MODE_ONE);
        run_cycle(MODE_ONE);

        // Round-robin between requesters 1 and 2.
        do_reset(1);
        want = 3'b110;
        a_r[1] = 16'h0100;
        a_r[2] = 16'h0200;
        for (int k = 0; k < 6; k++) begin
            run_cycle(MODE_HOLD);
            check("rr_seq", 32'(dut_gnt), (k % 2 == 0) ? 32'(3'b010) : 32'(3'b100));
        end
        want = '0;
        run_cycle(MODE_HOLD);

        // Starvation guard with all three requesting.
        do_reset(1);
        want = 3'b111;
        for (int k = 0; k < 12; k++) begin
            run_cycle(MODE_HOLD);
            check("starve_seq", 32'(dut_gnt), 32'(starve_seq[k]));
        end

        // Requester 0 alone: every cycle granted, no starvation counting.
        want = 3'b001;
        for (int k = 0; k < 10; k++) begin
            run_cycle(MODE_HOLD);
            check("prio_only_gnt", 32'(dut_gnt), 32'(3'b001));
            check("prio_only_starve_cnt", 32'(dut.starve_cnt), 32'(0));
        end

        // Reset in the cycle after a grant to requester 2 drops the return.
        want = 3'b100;
        run_cycle(MODE_ONE);
        check("pre_reset_gnt2", 32'(dut_gnt), 32'(3'b100));
        want = 3'b111;
        do_reset(1);
        want = 3'b011;
        run_cycle(MODE_ONE);
        check("post_reset_gnt0", 32'(dut_gnt), 32'(3'b001));
        run_cycle(MODE_ONE);
        check("post_reset_gnt1", 32'(dut_gnt), 32'(3'b010));
        // rr_ptr is now 2; a reset must bring it back to 1.
        want = 3'b110;
        do_reset(1);
        run_cycle(MODE_HOLD);
        check("rr_ptr_reset_gnt1", 32'(dut_gnt), 32'(3'b010));
        want = '0;
        run_cycle(MODE_HOLD);

        // Random traffic obeying the hold-until-granted rule.
        for (int k = 0; k < 300; k++) run_cycle(MODE_RAND);
        want = '0;
        run_cycle(MODE_HOLD);
        run_cycle(MODE_HOLD);

        // RD_LAT=3 instance: back-to-back stream from requester 1.
        for (int k = 0; k < 8; k++) cycle3(1'b1, AW'(k));
        for (int k = 0; k < 6; k++) cycle3(1'b0, '0);

        check("queues_drained", 32'(exp_q.size() + exp3_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares one synchronous ROM read port (registered output, `ce`-gated) between `NREQ` requesters. Requester 0 is the real-time video fetch path with fixed priority, bounded by a starvation guard. The remaining requesters (pattern generators, font/OSD fetch) are served round-robin. It sits between the fetch engines and the ROM instance, drives the ROM's `ce`/`address`, and routes each returned word back to its issuer with a pipelined tag.

## Interface
- `AW`, 16: ROM address width.
- `DW`, 8: ROM data width.
- `NREQ`, 3: number of requesters; must be ≥2.
- `RD_LAT`, 1: ROM read latency in cycles, from `rom_ce` to `rom_q` valid; must be ≥1.
- `STARVE_MAX`, 4: maximum consecutive grants to requester 0 while any other requester is pending; must be ≥1.
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester read request, level.
- `addr`  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- `gnt`  out  NREQ  one-hot; the read for that requester is issued this cycle.
- `rvalid`  out  NREQ  one-hot; `rdata` belongs to that requester this cycle.
- `rdata`  out  DW  read data, a direct pass-through of `rom_q`.
- `rom_ce`  out  1  ROM clock enable.
- `rom_address`  out  AW  ROM address.
- `rom_q`  in  DW  ROM data.

## Operation
- Handshake:
  - Requester i holds `req[i]` and its `addr` stable until it samples `gnt[i]`=1.
  - Each cycle with `gnt[i]`=1 accepts exactly one read.
  - The requester may keep `req` high and present a new address the cycle after `gnt` to stream back-to-back reads.
- Throughput is one issue per cycle and there are no bubbles.
- `gnt`, `rom_ce` and `rom_address` are combinational from `req`, `addr` and the registered arbiter state:
  - `rom_ce` is the OR of `gnt`.
  - `rom_address` equals the granted requester's `addr`.
  - When nothing is granted, `rom_address` is 0.
- Priority decision, each cycle:
  - `others` = any of `req[NREQ-1:1]`.
  - If `req[0]` and (`!others` or `starve_cnt < STARVE_MAX`), grant 0.
  - Otherwise, if `others`, grant the first requesting index in 1..NREQ-1 scanning cyclically from `rr_ptr`.
  - Otherwise, no grant.
- `starve_cnt` (width clog2(STARVE_MAX+1)):
  - Increments, saturating, on a grant to 0 while `others`.
  - Clears to 0 on any grant to i≥1, or when `others`=0.
  - Holds otherwise.
- `rr_ptr` (range 1..NREQ-1):
  - On a grant to i≥1, becomes i+1, wrapping from NREQ-1 to 1.
  - Unchanged otherwise.
- Tag pipeline: `RD_LAT` stages of {valid, one-hot id}. Stage 0 loads {`rom_ce`, `gnt`} and the entries shift every cycle.
- `rvalid` is the final stage's id, gated by its valid bit. Returns are strictly in issue order, one per grant.
- `rdata` = `rom_q`, unregistered. It is meaningful only when `rvalid` is non-zero.

## Timing
- Read latency is `RD_LAT` cycles: a `gnt[i]` in cycle T gives `rvalid[i]`=1 in cycle T+RD_LAT, with data for the address issued in T.
- Async reset (`reset_n`=0):
  - `rr_ptr`=1, `starve_cnt`=0, all tag stages invalid.
  - `gnt`, `rom_ce`, `rvalid` are forced to 0 and `rom_address` to 0 while `reset_n`=0, regardless of `req`.
  - `rdata` follows `rom_q`.
- Reset mid-operation drops every in-flight read. No `rvalid` is produced for grants issued before reset, and requesters must re-request.
- Simultaneous events:
  - Requester 0 and others both requesting at the starvation limit: exactly one other requester is granted, and requester 0 wins again next cycle.
  - A requester dropping `req` in the same cycle it would be granted is not granted.
- Reads are never stalled. The ROM `ce` is asserted only on issue cycles. Result capture is the requester's duty in the `rvalid` cycle.

## Structure
- Package `rom_arb_pkg`:
  - Parameter-check function (NREQ≥2, RD_LAT≥1, STARVE_MAX≥1).
  - Typedef for the tag struct {valid, id}.
- Sub-module `rom_rr_picker`: combinational cyclic first-one finder over `req[NREQ-1:1]` from `rr_ptr`. Returns a one-hot result and the index.
- Top: priority/starvation logic, `rr_ptr` and `starve_cnt` registers, tag shift register, and the output mux for `rom_address`.

## Test plan
Setup: NREQ=3, RD_LAT=1, STARVE_MAX=3, ROM preloaded with d[a] = a[7:0] ^ 8'h5A.

- Single read: `req[1]`=1, addr=16'h0010 in cycle T → `gnt`=3'b010 and `rom_address`=16'h0010 in T; `rvalid`=3'b010, `rdata`=8'h4A in T+1.
- Round-robin: `req[2:1]` held high, addresses incremented after each grant → `gnt` alternates 010, 100, 010, with `rvalid` trailing by one cycle and all data correct.
- Starvation guard: all three `req` held high → grant sequence 0,0,0,1,0,0,0,2,0,0,0,1 repeating.
- Priority without contention: only `req[0]` high for 10 cycles → 10 consecutive grants to 0, `starve_cnt` stays 0, no gaps.
- Reset mid-flight: assert `reset_n`=0 in the cycle after `gnt[2]` → `rvalid`=0 immediately. After release, the first grant goes to 0 if requested, otherwise to 1 (`rr_ptr`=1).
- RD_LAT=3 variant: a back-to-back stream from requester 1 at addresses 0..7 → `rvalid[1]` for 8 consecutive cycles starting 3 cycles after the first grant, with `rdata` = 5A, 5B, 58, 59, 5E, 5F, 5C, 5D.
